lfsr_sng_multi: RTL and testbench

//  Parametrised Fibonacci LFSR with NCH decorrelated OUT_W-bit random channels and a per-channel

---
 rtl/lfsr_pkg.sv | 89 ++++++++
 rtl/lfsr_core.sv | 82 ++++++++
 rtl/lfsr_sng_multi.sv | 94 +++++++++
 tb/tb_lfsr_sng_multi.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and elaboration helpers for the LFSR random source.
// Tap masks are Fibonacci (shift-left) masks of primitive polynomials.
package lfsr_pkg;

  localparam int unsigned MIN_W         = 4;
  localparam int unsigned MAX_W         = 32;
  localparam int unsigned MAX_NCH       = 8;
  localparam int unsigned PERM_STEP_DEF = 7;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2
  } lfsr_op_e;

  function automatic logic [31:0] default_taps(
    input int unsigned w
  );
    logic [31:0] t;
    t = 32'h0;
    unique case (w)
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_8016;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = 32'h0;
    endcase
    return t;
  endfunction

  function automatic int unsigned gcd(
    input int unsigned a,
    input int unsigned b
  );
    int unsigned x;
    int unsigned y;
    int unsigned r;
    x = a;
    y = b;
    while (y != 0) begin
      r = x % y;
      x = y;
      y = r;
    end
    return x;
  endfunction

  function automatic bit perm_ok(
    input int unsigned step,
    input int unsigned w
  );
    return ((step % 2) == 1) && (gcd(step, w) == 1);
  endfunction

  function automatic int unsigned perm_idx(
    input int unsigned c,
    input int unsigned k,
    input int unsigned step,
    input int unsigned w
  );
    return (c + k * step) % w;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state with seed load, zero-seed fixup and wrap detect.
// A zero seed would lock the register, so it is replaced by 1.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(default_taps(WIDTH))
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             seed_ld_i,
  input  logic [WIDTH-1:0] seed_i,
  output lfsr_op_e         op_o,
  output logic [WIDTH-1:0] state_o,
  output logic             wrap_o,
  output logic             lockup_o
);

  lfsr_op_e         op;
  logic             load;
  logic             seed_zero;
  logic [WIDTH-1:0] seed_fix;
  logic [WIDTH-1:0] step_val;
  logic             fb;

  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] seed_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             lock_q;
  logic             lock_d;

  assign load      = rst_i | seed_ld_i;
  assign seed_zero = (seed_i == '0);
  assign seed_fix  = seed_zero ? WIDTH'(1) : seed_i;
  assign fb        = ^(d_q & TAP_MASK);
  assign step_val  = {d_q[WIDTH-2:0], fb};

  always_comb begin
    op = OP_HOLD;
    unique case (1'b1)
      load:          op = OP_LOAD;
      en_i && !load: op = OP_STEP;
      default:       op = OP_HOLD;
    endcase
  end

  always_comb begin
    d_d    = d_q;
    seed_d = seed_q;
    wrap_d = 1'b0;
    lock_d = 1'b0;
    unique case (op)
      OP_LOAD: begin
        d_d    = seed_fix;
        seed_d = seed_fix;
        lock_d = seed_zero;
      end
      OP_STEP: begin
        d_d    = step_val;
        wrap_d = (step_val == seed_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    d_q    <= d_d;
    seed_q <= seed_d;
    wrap_q <= wrap_d;
    lock_q <= lock_d;
  end

  assign op_o     = op;
  assign state_o  = d_q;
  assign wrap_o   = wrap_q;
  assign lockup_o = lock_q;

endmodule

// File: rtl/lfsr_sng_multi.sv
// Multi-channel LFSR random source with per-channel stochastic bits.
// Channels pick state bits with a stride so they stay decorrelated.
module lfsr_sng_multi
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(default_taps(WIDTH)),
  parameter int unsigned      NCH       = 2,
  parameter int unsigned      OUT_W     = 8,
  parameter int unsigned      PERM_STEP = PERM_STEP_DEF
) (
  input  logic                 TRIG,
  input  logic                 RESET,
  input  logic                 EN,
  input  logic                 SEED_LD,
  input  logic [WIDTH-1:0]     SEED,
  input  logic [NCH*OUT_W-1:0] PROB,
  output logic [NCH*OUT_W-1:0] RND,
  output logic [NCH-1:0]       SBIT,
  output logic                 SBIT_VALID,
  output logic                 WRAP,
  output logic                 LOCKUP
);

  if (WIDTH < MIN_W || WIDTH > MAX_W) begin : g_bad_width
    $error("WIDTH out of range");
  end
  if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
    $error("NCH out of range");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_outw
    $error("OUT_W must not exceed WIDTH");
  end
  if (!perm_ok(PERM_STEP, WIDTH)) begin : g_bad_perm
    $error("PERM_STEP must be odd and coprime with WIDTH");
  end

  lfsr_op_e         op;
  logic [WIDTH-1:0] state;
  logic [NCH-1:0]   hit;

  logic [NCH-1:0]   sbit_q;
  logic [NCH-1:0]   sbit_d;
  logic             valid_q;
  logic             valid_d;

  lfsr_core #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK)
  ) u_core (
    .clk_i     (TRIG),
    .rst_i     (RESET),
    .en_i      (EN),
    .seed_ld_i (SEED_LD),
    .seed_i    (SEED),
    .op_o      (op),
    .state_o   (state),
    .wrap_o    (WRAP),
    .lockup_o  (LOCKUP)
  );

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    for (genvar k = 0; k < OUT_W; k++) begin : g_bit
      localparam int unsigned IDX =
        perm_idx(c, k, PERM_STEP, WIDTH);
      assign RND[c*OUT_W+k] = state[IDX];
    end
    // compare uses the pre-step state, so SBIT lags RND by one step
    assign hit[c] =
      RND[c*OUT_W +: OUT_W] < PROB[c*OUT_W +: OUT_W];
  end

  always_comb begin
    sbit_d  = sbit_q;
    valid_d = 1'b0;
    unique case (op)
      OP_LOAD: sbit_d = '0;
      OP_STEP: begin
        sbit_d  = hit;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge TRIG) begin
    sbit_q  <= sbit_d;
    valid_q <= valid_d;
  end

  assign SBIT       = sbit_q;
  assign SBIT_VALID = valid_q;

endmodule

// File: tb/tb_lfsr_sng_multi.sv
// Scoreboard bench for lfsr_sng_multi (16-bit, 2 channels) and a 4-bit
// instance used for the short-period wrap check.
module tb_lfsr_sng_multi;

  typedef struct packed {
    logic [15:0] rnd;
    logic [1:0]  sbit;
    logic        valid;
    logic        wrap;
    logic        lock;
  } obs_t;

  typedef struct packed {
    logic [3:0] rnd;
    logic       wrap;
  } obs4_t;

  logic trig = 1'b0;
  always #5 trig = ~trig;

  logic        rst, ld, en;
  logic [15:0] seed, prob;
  logic [15:0] rnd;
  logic [1:0]  sbit;
  logic        sv, wrap, lock;

  logic       rst4, ld4, en4;
  logic [3:0] seed4, prob4, rnd4;
  logic       sbit4, sv4, wrap4, lock4;

  int checks = 0;
  int errors = 0;

  obs_t  exp_q[$];
  obs4_t exp4_q[$];

  logic [15:0] md, mseed;
  logic [1:0]  msbit;
  logic        mv, mw, ml;

  lfsr_sng_multi #(
    .WIDTH(16), .TAP_MASK(16'h8016), .NCH(2),
    .OUT_W(8), .PERM_STEP(7)
  ) dut (
    .TRIG(trig), .RESET(rst), .EN(en), .SEED_LD(ld),
    .SEED(seed), .PROB(prob), .RND(rnd), .SBIT(sbit),
    .SBIT_VALID(sv), .WRAP(wrap), .LOCKUP(lock)
  );

  lfsr_sng_multi #(
    .WIDTH(4), .TAP_MASK(4'h9), .NCH(1),
    .OUT_W(4), .PERM_STEP(7)
  ) dut4 (
    .TRIG(trig), .RESET(rst4), .EN(en4), .SEED_LD(ld4),
    .SEED(seed4), .PROB(prob4), .RND(rnd4), .SBIT(sbit4),
    .SBIT_VALID(sv4), .WRAP(wrap4), .LOCKUP(lock4)
  );

  function automatic logic [15:0] mrnd(input logic [15:0] d);
    logic [15:0] r;
    r = '0;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 8; k++)
        r[c*8+k] = d[(c + k*7) % 16];
    return r;
  endfunction

  function automatic obs_t sample();
    return {rnd, sbit, sv, wrap, lock};
  endfunction

  task automatic cyc(input logic r, input logic l,
                     input logic e, input logic [15:0] s,
                     input logic [15:0] p);
    logic [15:0] rr;
    logic [15:0] nd;
    rst = r; ld = l; en = e; seed = s; prob = p;
    if (r || l) begin
      nd = (s == 16'h0) ? 16'h0001 : s;
      md = nd; mseed = nd; ml = (s == 16'h0);
      msbit = 2'b00; mv = 1'b0; mw = 1'b0;
    end else if (e) begin
      rr = mrnd(md);
      msbit = {rr[15:8] < p[15:8], rr[7:0] < p[7:0]};
      mv = 1'b1;
      nd = {md[14:0], ^(md & 16'h8016)};
      mw = (nd == mseed);
      ml = 1'b0;
      md = nd;
    end else begin
      mv = 1'b0; mw = 1'b0; ml = 1'b0;
    end
    exp_q.push_back({mrnd(md), msbit, mv, mw, ml});
    @(posedge trig);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, ex;
    rst4 = 1'b1; ld4 = 1'b0; en4 = 1'b0;
    seed4 = 4'h1; prob4 = 4'h0;
    cyc(1, 0, 0, 16'h0001, 16'h0000);
    rst4 = 1'b0;
    got = sample(); ex = exp_q.pop_front(); checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", got, ex);
    end
  endtask

  task automatic test_step_seq();
    obs_t got, ex;
    logic [15:0] seq [3];
    seq[0] = 16'h0002; seq[1] = 16'h0005; seq[2] = 16'h000B;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 16'h0001, 16'h4040);
      got = sample(); ex = exp_q.pop_front(); checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL step%0d got=%h exp=%h", i, got, ex);
      end
      checks++;
      if (rnd !== mrnd(seq[i]) || lock !== 1'b0) begin
        errors++;
        $display("FAIL seq%0d rnd=%h lock=%b exp rnd=%h lock=0",
                 i, rnd, lock, mrnd(seq[i]));
      end
    end
  endtask

  task automatic test_zero_seed();
    obs_t got, ex;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) cyc(1, 0, 0, 16'h0000, 16'h0000);
      else        cyc(0, 0, 0, 16'h0000, 16'h0000);
      got = sample(); ex = exp_q.pop_front(); checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL zseed%0d got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  task automatic test_wrap4();
    logic [3:0] d4;
    obs4_t got, ex;
    int wraps = 0;
    en4 = 1'b1;
    d4 = 4'h1;
    for (int n = 1; n <= 45; n++) begin
      d4 = {d4[2:0], d4[3] ^ d4[0]};
      exp4_q.push_back({d4[1], d4[2], d4[3], d4[0], (n % 15) == 0});
      @(posedge trig);
      #1;
      got = {rnd4, wrap4}; ex = exp4_q.pop_front(); checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL wrap4 n=%0d got=%h exp=%h", n, got, ex);
      end
      if (wrap4 === 1'b1) wraps++;
    end
    en4 = 1'b0;
    checks++;
    if (wraps !== 3) begin
      errors++;
      $display("FAIL wrap4cnt got=%0d exp=3", wraps);
    end
  endtask

  task automatic test_prob_extremes();
    obs_t got, ex;
    int ones0 = 0;
    cyc(1, 0, 0, 16'hBEEF, 16'hFF00);
    void'(exp_q.pop_front());
    for (int i = 0; i < 1000; i++) begin
      cyc(0, 0, 1, 16'h0000, 16'hFF00);
      got = sample(); ex = exp_q.pop_front(); checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL prob_ext%0d got=%h exp=%h", i, got, ex);
      end
      if (sbit[0] === 1'b1) ones0++;
    end
    checks++;
    if (ones0 !== 0) begin
      errors++;
      $display("FAIL prob0 ones got=%0d exp=0", ones0);
    end
  endtask

  task automatic test_full_period();
    obs_t got, ex;
    int ones = 0;
    int wraps = 0;
    int errs = 0;
    cyc(1, 0, 0, 16'hACE1, 16'h8080);
    void'(exp_q.pop_front());
    for (int i = 0; i < 65535; i++) begin
      cyc(0, 0, 1, 16'h0000, 16'h8080);
      got = sample(); ex = exp_q.pop_front(); checks++;
      if (got !== ex) begin
        errors++;
        errs++;
        if (errs < 5)
          $display("FAIL period%0d got=%h exp=%h", i, got, ex);
      end
      if (sbit[0] === 1'b1) ones++;
      if (wrap === 1'b1) wraps++;
    end
    checks++;
    if (ones !== 32767) begin
      errors++;
      $display("FAIL half_cnt got=%0d exp=32767", ones);
    end
    checks++;
    if (wraps !== 1 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL period_wrap got=%0d last=%b exp=1", wraps, wrap);
    end
  endtask

  task automatic test_seed_ld();
    obs_t got, ex;
    cyc(1, 0, 0, 16'h00FF, 16'h3377);
    void'(exp_q.pop_front());
    for (int i = 0; i < 9; i++) begin
      if (i == 4)      cyc(0, 1, 1, 16'h1234, 16'h3377);
      else if (i == 8) cyc(1, 1, 1, 16'h0000, 16'h3377);
      else             cyc(0, 0, 1, 16'h5555, 16'h3377);
      got = sample(); ex = exp_q.pop_front(); checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL seedld%0d got=%h exp=%h", i, got, ex);
      end
      if (i == 4) begin
        checks++;
        if (rnd !== mrnd(16'h1234) || sv !== 1'b0) begin
          errors++;
          $display("FAIL ld1234 rnd=%h v=%b exp rnd=%h v=0",
                   rnd, sv, mrnd(16'h1234));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, ex;
    logic r, l, e;
    logic [15:0] s;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 63) == 0);
      l = ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cyc(r, l, e, s, 16'($urandom));
      got = sample(); ex = exp_q.pop_front(); checks++;
      if (got !== ex) begin
        errors++;
        $display("FAIL b2b%0d got=%h exp=%h", i, got, ex);
      end
    end
  endtask

  initial begin
    rst = 1'b0; ld = 1'b0; en = 1'b0;
    seed = '0; prob = '0;
    rst4 = 1'b0; ld4 = 1'b0; en4 = 1'b0;
    seed4 = '0; prob4 = '0;
    @(posedge trig);
    #1;
    test_reset();
    test_step_seq();
    test_zero_seed();
    test_wrap4();
    test_prob_extremes();
    test_full_period();
    test_seed_ld();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
